// File: rtl/mapa_arbiter.sv
// Map write arbiter: clears the map RAM on reset or on request, then grants update/fruta/obstaculo writes.
// Define MAPA_ARB_RR_EN for round-robin arbitration; otherwise fixed priority update > fruta > obstaculo.
module mapa_arbiter #(
   parameter int MAPA_WIDTH  = 40,
   parameter int MAPA_HEIGHT = 30
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear_req,
   output logic       busy,
   input  logic       update_req,
   input  logic       fruta_req,
   input  logic       obstaculo_req,
   input  logic [9:0] update_wx,
   input  logic [9:0] update_wy,
   input  logic [9:0] fruta_wx,
   input  logic [9:0] fruta_wy,
   input  logic [9:0] obstaculo_wx,
   input  logic [9:0] obstaculo_wy,
   input  logic [1:0] update_wdata,
   output logic       update_gnt,
   output logic       fruta_gnt,
   output logic       obstaculo_gnt,
   output logic       mapa_wenable,
   output logic [9:0] mapa_wx,
   output logic [9:0] mapa_wy,
   output logic [1:0] mapa_wdata,
   output logic       err_oob
);

   // state | meaning
   // CLEAR | sweeping code 0 into every cell, x fastest; no grants
   // RUN   | arbitrating requester writes
   typedef enum logic {CLEAR, RUN} state_t;

   localparam logic [9:0] W_LIM  = 10'(MAPA_WIDTH);
   localparam logic [9:0] H_LIM  = 10'(MAPA_HEIGHT);
   localparam logic [9:0] X_LAST = 10'(MAPA_WIDTH - 1);
   localparam logic [9:0] Y_LAST = 10'(MAPA_HEIGHT - 1);

   state_t     state;
   logic [9:0] sweep_x;
   logic [9:0] sweep_y;
   logic [2:0] req_vec;
   logic [2:0] gnt_vec;
   logic       arb_en;
   logic [9:0] sel_x;
   logic [9:0] sel_y;
   logic [1:0] sel_d;
   logic       sel_oob;

   assign req_vec = {obstaculo_req, fruta_req, update_req};
   assign arb_en  = reset && (state == RUN) && !clear_req;

`ifdef MAPA_ARB_RR_EN
   // rr_ptr names the requester searched first: 0 update, 1 fruta, 2 obstaculo
   logic [1:0] rr_ptr;

   always_comb begin
      gnt_vec = 3'b000;
      if (arb_en) begin
         case (rr_ptr)
            2'd1:    gnt_vec = req_vec[1] ? 3'b010 : req_vec[2] ? 3'b100 : req_vec[0] ? 3'b001 : 3'b000;
            2'd2:    gnt_vec = req_vec[2] ? 3'b100 : req_vec[0] ? 3'b001 : req_vec[1] ? 3'b010 : 3'b000;
            default: gnt_vec = req_vec[0] ? 3'b001 : req_vec[1] ? 3'b010 : req_vec[2] ? 3'b100 : 3'b000;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset)          rr_ptr <= 2'd0;
      else if (gnt_vec[0]) rr_ptr <= 2'd1;
      else if (gnt_vec[1]) rr_ptr <= 2'd2;
      else if (gnt_vec[2]) rr_ptr <= 2'd0;
   end
`else
   always_comb begin
      gnt_vec = 3'b000;
      if (arb_en) begin
         if (req_vec[0])      gnt_vec = 3'b001;
         else if (req_vec[1]) gnt_vec = 3'b010;
         else if (req_vec[2]) gnt_vec = 3'b100;
      end
   end
`endif

   assign update_gnt    = gnt_vec[0];
   assign fruta_gnt     = gnt_vec[1];
   assign obstaculo_gnt = gnt_vec[2];
   assign busy          = !reset || (state == CLEAR);

   always_comb begin
      sel_x = update_wx;
      sel_y = update_wy;
      sel_d = update_wdata;
      if (gnt_vec[1]) begin
         sel_x = fruta_wx;
         sel_y = fruta_wy;
         sel_d = 2'd2;
      end else if (gnt_vec[2]) begin
         sel_x = obstaculo_wx;
         sel_y = obstaculo_wy;
         sel_d = 2'd3;
      end
   end

   assign sel_oob = (sel_x >= W_LIM) || (sel_y >= H_LIM);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= CLEAR;
         sweep_x      <= '0;
         sweep_y      <= '0;
         mapa_wenable <= 1'b0;
         mapa_wx      <= '0;
         mapa_wy      <= '0;
         mapa_wdata   <= '0;
         err_oob      <= 1'b0;
      end else begin
         mapa_wenable <= 1'b0;
         err_oob      <= 1'b0;
         case (state)
            CLEAR: begin
               mapa_wenable <= 1'b1;
               mapa_wx      <= sweep_x;
               mapa_wy      <= sweep_y;
               mapa_wdata   <= 2'd0;
               if (sweep_x == X_LAST) begin
                  sweep_x <= '0;
                  if (sweep_y == Y_LAST) begin
                     sweep_y <= '0;
                     state   <= RUN;
                  end else begin
                     sweep_y <= sweep_y + 10'd1;
                  end
               end else begin
                  sweep_x <= sweep_x + 10'd1;
               end
            end
            RUN: begin
               if (clear_req) begin
                  state   <= CLEAR;
                  sweep_x <= '0;
                  sweep_y <= '0;
               end else if (gnt_vec != 3'b000) begin
                  // dropped writes leave the RAM port coordinates untouched
                  if (sel_oob) begin
                     err_oob <= 1'b1;
                  end else begin
                     mapa_wenable <= 1'b1;
                     mapa_wx      <= sel_x;
                     mapa_wy      <= sel_y;
                     mapa_wdata   <= sel_d;
                  end
               end
            end
            default: state <= CLEAR;
         endcase
      end
   end

endmodule
